lsu_46: RTL and testbench

LSU_46 -- requirements
Module: lsu_46

---
 rtl/lsu_46_pkg.sv | 46 ++++
 rtl/lsu_lane_46.sv | 48 ++++
 rtl/lsu_46.sv | 145 ++++++++++++++
 tb/tb_lsu_46.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_46_pkg.sv
// lsu_46_pkg: shared state encoding, access-size codes, lane widths and small
// address helpers for the lsu_46 load/store unit.
package lsu_46_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned HALF_W = 16;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_STORE,
      ST_RMW_RD,
      ST_RMW_WR,
      ST_RESP
   } state_e;

   // Size code 11 behaves exactly like a word access.
   function automatic logic [1:0] norm_size(input logic [1:0] sz);
      return (sz == 2'b11) ? SZ_WORD : sz;
   endfunction

   // Lane offset within the word, with the bits a size ignores masked off.
   function automatic logic [1:0] lane_off(input logic [1:0] sz, input logic [1:0] a);
      case (sz)
         SZ_BYTE: return a;
         SZ_HALF: return {a[1], 1'b0};
         default: return 2'b00;
      endcase
   endfunction

   // True when the access does not sit on its natural boundary.
   function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
      case (sz)
         SZ_HALF: return a[0];
         SZ_WORD: return (a != 2'b00);
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_lane_46.sv
// lsu_lane_46: combinational lane logic -- extracts a byte/halfword from a
// memory word with zero/sign extension, and merges store data into a word.
module lsu_lane_46
   import lsu_46_pkg::*;
(
   input  logic [1:0]        size,
   input  logic              sign_ext,
   input  logic [1:0]        off,
   input  logic [DATA_W-1:0] word,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] load_data_c,
   output logic [DATA_W-1:0] merged_c
);

   logic [4:0]        shamt;
   logic [BYTE_W-1:0] byte_v;
   logic [HALF_W-1:0] half_v;
   logic [DATA_W-1:0] mask;

   // Little-endian lane select, extension and lane replacement.
   always_comb begin
      shamt       = {off, 3'b000};
      byte_v      = BYTE_W'(word >> shamt);
      half_v      = HALF_W'(word >> shamt);
      mask        = '0;
      load_data_c = word;
      merged_c    = wdata;
      case (size)
         SZ_BYTE: begin
            load_data_c = sign_ext ? {{(DATA_W-BYTE_W){byte_v[BYTE_W-1]}}, byte_v}
                                   : DATA_W'(byte_v);
            mask        = DATA_W'({BYTE_W{1'b1}}) << shamt;
            merged_c    = (word & ~mask) | ((DATA_W'(wdata[BYTE_W-1:0]) << shamt) & mask);
         end
         SZ_HALF: begin
            load_data_c = sign_ext ? {{(DATA_W-HALF_W){half_v[HALF_W-1]}}, half_v}
                                   : DATA_W'(half_v);
            mask        = DATA_W'({HALF_W{1'b1}}) << shamt;
            merged_c    = (word & ~mask) | ((DATA_W'(wdata[HALF_W-1:0]) << shamt) & mask);
         end
         default: begin
            load_data_c = word;
            merged_c    = wdata;
         end
      endcase
   end

endmodule

// File: rtl/lsu_46.sv
// lsu_46: multi-cycle load/store unit with read-modify-write for sub-word
// stores. Optional misalignment trap: define LSU_46_MISALIGN_TRAP_EN.
module lsu_46
   import lsu_46_pkg::*;
(
   input  logic              clk_46,
   input  logic              rst_n_46,
   input  logic              req_valid_46,
   output logic              req_ready_46,
   input  logic              req_we_46,
   input  logic [1:0]        req_size_46,
   input  logic              req_signed_46,
   input  logic [ADDR_W-1:0] req_addr_46,
   input  logic [DATA_W-1:0] req_wdata_46,
   output logic              resp_valid_46,
   output logic [DATA_W-1:0] resp_rdata_46,
   output logic              resp_err_46,
   output logic [ADDR_W-1:0] mem_waddr_46,
   output logic [DATA_W-1:0] mem_wdata_46,
   output logic              mem_write_46,
   output logic [ADDR_W-1:0] mem_raddr_46,
   input  logic [DATA_W-1:0] mem_rdata_46
);

   state_e            state;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        off_q;
   logic [1:0]        size_q;
   logic              signed_q;
   logic [DATA_W-1:0] wdata_q;
   logic [1:0]        sz_c;
   logic              trap_c;
   logic [DATA_W-1:0] load_data_c;
   logic [DATA_W-1:0] merged_c;

   assign sz_c = norm_size(req_size_46);

`ifdef LSU_46_MISALIGN_TRAP_EN
   logic err_q;
   assign trap_c      = misaligned(sz_c, req_addr_46[1:0]);
   assign resp_err_46 = err_q;
`else
   assign trap_c      = 1'b0;
   assign resp_err_46 = 1'b0;
`endif

   // Both memory ports are addressed only by the registered aligned address.
   assign mem_raddr_46 = addr_q;
   assign mem_waddr_46 = addr_q;

   lsu_lane_46 u_lane (
      .size        (size_q),
      .sign_ext    (signed_q),
      .off         (off_q),
      .word        (mem_rdata_46),
      .wdata       (wdata_q),
      .load_data_c (load_data_c),
      .merged_c    (merged_c)
   );

   // Access sequencer with registered handshake, response and write-port outputs.
   always_ff @(posedge clk_46 or negedge rst_n_46) begin
      if (!rst_n_46) begin
         state         <= ST_IDLE;
         req_ready_46  <= 1'b1;
         resp_valid_46 <= 1'b0;
         resp_rdata_46 <= '0;
         mem_write_46  <= 1'b0;
         mem_wdata_46  <= '0;
         addr_q        <= '0;
         off_q         <= '0;
         size_q        <= '0;
         signed_q      <= 1'b0;
         wdata_q       <= '0;
`ifdef LSU_46_MISALIGN_TRAP_EN
         err_q         <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid_46 && req_ready_46) begin
                  req_ready_46 <= 1'b0;
                  addr_q       <= {req_addr_46[ADDR_W-1:2], 2'b00};
                  off_q        <= lane_off(sz_c, req_addr_46[1:0]);
                  size_q       <= sz_c;
                  signed_q     <= req_signed_46;
                  wdata_q      <= req_wdata_46;
                  if (trap_c) begin
                     state         <= ST_RESP;
                     resp_valid_46 <= 1'b1;
                     resp_rdata_46 <= '0;
`ifdef LSU_46_MISALIGN_TRAP_EN
                     err_q         <= 1'b1;
`endif
                  end else if (!req_we_46) begin
                     state <= ST_LOAD;
                  end else if (sz_c == SZ_WORD) begin
                     state        <= ST_STORE;
                     mem_write_46 <= 1'b1;
                     mem_wdata_46 <= req_wdata_46;
                  end else begin
                     state <= ST_RMW_RD;
                  end
               end
            end
            ST_LOAD: begin
               resp_rdata_46 <= load_data_c;
               resp_valid_46 <= 1'b1;
               state         <= ST_RESP;
            end
            ST_STORE: begin
               mem_write_46  <= 1'b0;
               resp_valid_46 <= 1'b1;
               state         <= ST_RESP;
            end
            ST_RMW_RD: begin
               mem_wdata_46 <= merged_c;
               mem_write_46 <= 1'b1;
               state        <= ST_RMW_WR;
            end
            ST_RMW_WR: begin
               mem_write_46  <= 1'b0;
               resp_valid_46 <= 1'b1;
               state         <= ST_RESP;
            end
            ST_RESP: begin
               resp_valid_46 <= 1'b0;
               resp_rdata_46 <= '0;
               req_ready_46  <= 1'b1;
`ifdef LSU_46_MISALIGN_TRAP_EN
               err_q         <= 1'b0;
`endif
               state         <= ST_IDLE;
            end
            default: begin
               mem_write_46  <= 1'b0;
               resp_valid_46 <= 1'b0;
               req_ready_46  <= 1'b1;
               state         <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_46.sv
// tb_lsu_46: directed table-driven bench for lsu_46 with a small word memory.
module tb_lsu_46;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_waddr;
   logic [31:0] mem_wdata;
   logic        mem_write;
   logic [31:0] mem_raddr;
   logic [31:0] mem_rdata;

   logic [31:0] mem [64];
   logic        pre_we = 1'b0;
   logic [5:0]  pre_idx = '0;
   logic [31:0] pre_data = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lsu_46 dut (
      .clk_46        (clk),
      .rst_n_46      (rst_n),
      .req_valid_46  (req_valid),
      .req_ready_46  (req_ready),
      .req_we_46     (req_we),
      .req_size_46   (req_size),
      .req_signed_46 (req_signed),
      .req_addr_46   (req_addr),
      .req_wdata_46  (req_wdata),
      .resp_valid_46 (resp_valid),
      .resp_rdata_46 (resp_rdata),
      .resp_err_46   (resp_err),
      .mem_waddr_46  (mem_waddr),
      .mem_wdata_46  (mem_wdata),
      .mem_write_46  (mem_write),
      .mem_raddr_46  (mem_raddr),
      .mem_rdata_46  (mem_rdata)
   );

   // Word memory: combinational read, write on the rising edge, bench preload port.
   assign mem_rdata = mem[mem_raddr[7:2]];
   always @(posedge clk) begin
      if (mem_write) mem[mem_waddr[7:2]] <= mem_wdata;
      else if (pre_we) mem[pre_idx] <= pre_data;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   task automatic poke(input logic [5:0] idx, input logic [31:0] d);
      pre_we = 1'b1; pre_idx = idx; pre_data = d;
      @(posedge clk); #1;
      pre_we = 1'b0;
   endtask

   // Issue one access and follow it to its response pulse.
   task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er,
                         output int lat, output int wr, output logic ok);
      int n;
      ok = 1'b0; rd = '0; er = 1'b0; lat = 0; wr = 0;
      req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
      req_addr = a; req_wdata = wd;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!req_ready && n < 20);
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         if (mem_write) wr++;
         if (resp_valid) begin
            lat = c; rd = resp_rdata; er = resp_err; ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   typedef struct {
      logic        we;
      logic [1:0]  sz;
      logic        sg;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_err;
      int          exp_lat;
      int          exp_wr;
      logic [31:0] exp_word;
   } vec_t;

   vec_t vecs [18];

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;
      int          wr;
      logic        ok;
      int          seen;

      //            we    sz     sg    addr   wdata         rdata         err   lat wr word
      vecs[0]  = '{1'b0, 2'b10, 1'b0, 32'd60, 32'h0,        32'h00000002, 1'b0, 2, 0, 32'h00000002};
      vecs[1]  = '{1'b1, 2'b00, 1'b0, 32'd65, 32'hFFFFFFAB, 32'h0,        1'b0, 3, 1, 32'h1122AB44};
      vecs[2]  = '{1'b0, 2'b00, 1'b0, 32'd65, 32'h0,        32'h000000AB, 1'b0, 2, 0, 32'h1122AB44};
      vecs[3]  = '{1'b0, 2'b00, 1'b1, 32'd65, 32'h0,        32'hFFFFFFAB, 1'b0, 2, 0, 32'h1122AB44};
      vecs[4]  = '{1'b1, 2'b01, 1'b0, 32'd66, 32'h12345566, 32'h0,        1'b0, 3, 1, 32'h5566AB44};
      vecs[5]  = '{1'b0, 2'b01, 1'b1, 32'd66, 32'h0,        32'h00005566, 1'b0, 2, 0, 32'h5566AB44};
      vecs[6]  = '{1'b0, 2'b01, 1'b1, 32'd64, 32'h0,        32'hFFFFAB44, 1'b0, 2, 0, 32'h5566AB44};
      vecs[7]  = '{1'b1, 2'b10, 1'b0, 32'd64, 32'h80000000, 32'h0,        1'b0, 2, 1, 32'h80000000};
      vecs[8]  = '{1'b0, 2'b00, 1'b1, 32'd67, 32'h0,        32'hFFFFFF80, 1'b0, 2, 0, 32'h80000000};
      vecs[9]  = '{1'b0, 2'b00, 1'b0, 32'd67, 32'h0,        32'h00000080, 1'b0, 2, 0, 32'h80000000};
      vecs[11] = '{1'b1, 2'b10, 1'b0, 32'd72, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 32'hDEADBEEF};
      vecs[12] = '{1'b0, 2'b10, 1'b0, 32'd72, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0, 32'hDEADBEEF};
      vecs[13] = '{1'b0, 2'b11, 1'b0, 32'd80, 32'h0,        32'hCAFEF00D, 1'b0, 2, 0, 32'hCAFEF00D};
      vecs[14] = '{1'b0, 2'b01, 1'b0, 32'd82, 32'h0,        32'h0000CAFE, 1'b0, 2, 0, 32'hCAFEF00D};
`ifdef LSU_46_MISALIGN_TRAP_EN
      vecs[10] = '{1'b0, 2'b10, 1'b0, 32'd62, 32'h0,        32'h0,        1'b1, 1, 0, 32'h00000002};
      vecs[15] = '{1'b0, 2'b01, 1'b0, 32'd83, 32'h0,        32'h0,        1'b1, 1, 0, 32'hCAFEF00D};
      vecs[16] = '{1'b1, 2'b01, 1'b0, 32'd81, 32'h0000BBCC, 32'h0,        1'b1, 1, 0, 32'hCAFEF00D};
      vecs[17] = '{1'b0, 2'b00, 1'b1, 32'd80, 32'h0,        32'h0000000D, 1'b0, 2, 0, 32'hCAFEF00D};
`else
      vecs[10] = '{1'b0, 2'b10, 1'b0, 32'd62, 32'h0,        32'h00000002, 1'b0, 2, 0, 32'h00000002};
      vecs[15] = '{1'b0, 2'b01, 1'b0, 32'd83, 32'h0,        32'h0000CAFE, 1'b0, 2, 0, 32'hCAFEF00D};
      vecs[16] = '{1'b1, 2'b01, 1'b0, 32'd81, 32'h0000BBCC, 32'h0,        1'b0, 3, 1, 32'hCAFEBBCC};
      vecs[17] = '{1'b0, 2'b00, 1'b1, 32'd80, 32'h0,        32'hFFFFFFCC, 1'b0, 2, 0, 32'hCAFEBBCC};
`endif

      // Preload while reset is held, then check reset values.
      for (int i = 0; i < 64; i++) poke(6'(i), 32'h0);
      poke(6'd15, 32'h00000002);
      poke(6'd16, 32'h11223344);
      poke(6'd20, 32'hCAFEF00D);
      poke(6'd21, 32'h01020304);
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'h0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      chk("rst_mem_write", 32'(mem_write), 32'd0);
      chk("rst_mem_raddr", mem_raddr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 18; i++) begin
         do_req(vecs[i].we, vecs[i].sz, vecs[i].sg, vecs[i].addr, vecs[i].wdata, rd, er, lat, wr, ok);
         chk($sformatf("v%0d_resp_seen", i), 32'(ok), 32'd1);
         chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
         chk($sformatf("v%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
         chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
         chk($sformatf("v%0d_write_cycles", i), 32'(wr), 32'(vecs[i].exp_wr));
         chk($sformatf("v%0d_mem_word", i), mem[vecs[i].addr[7:2]], vecs[i].exp_word);
         @(posedge clk); #1;
         chk($sformatf("v%0d_pulse_end", i), 32'(resp_valid), 32'd0);
         chk($sformatf("v%0d_ready_back", i), 32'(req_ready), 32'd1);
      end

      // Reset during RMW_WR abandons the write and the response.
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
      req_addr = 32'd84; req_wdata = 32'h00000099;
      @(negedge clk);
      chk("rmw_ready_before", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("rmw_rd_no_write", 32'(mem_write), 32'd0);
      @(posedge clk); #1;
      chk("rmw_wr_write", 32'(mem_write), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_mem_write", 32'(mem_write), 32'd0);
      chk("rst_mid_ready", 32'(req_ready), 32'd1);
      chk("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
      seen = 0;
      repeat (2) begin
         @(posedge clk); #1;
         if (resp_valid) seen++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
         if (resp_valid) seen++;
      end
      chk("rst_mid_no_resp", 32'(seen), 32'd0);
      chk("rst_mid_mem_kept", mem[21], 32'h01020304);
      do_req(1'b0, 2'b10, 1'b0, 32'd84, 32'h0, rd, er, lat, wr, ok);
      chk("post_rst_resp_seen", 32'(ok), 32'd1);
      chk("post_rst_load", rd, 32'h01020304);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
